// File: rtl/ncpu32k_exc_pkg.sv
// ncpu32k_exc_pkg
// Shared definitions for the exception/interrupt sequencer: cause codes,
// PSR bit positions, sequencer state encoding and the vector spacing.
// No ports (package).
package ncpu32k_exc_pkg;

   // Cause codes; a lower code has higher priority
   localparam logic [3:0] CauseNone     = 4'd0;
   localparam logic [3:0] CauseItlbMiss = 4'd1;
   localparam logic [3:0] CauseIpf      = 4'd2;
   localparam logic [3:0] CauseIllegal  = 4'd3;
   localparam logic [3:0] CauseSyscall  = 4'd4;
   localparam logic [3:0] CauseDtlbMiss = 4'd5;
   localparam logic [3:0] CauseDpf      = 4'd6;
   localparam logic [3:0] CauseAlign    = 4'd7;
   localparam logic [3:0] CauseIrq      = 4'd8;

   // PSR bit positions
   localparam int unsigned PsrCc   = 0;
   localparam int unsigned PsrRm   = 4;
   localparam int unsigned PsrIre  = 5;
   localparam int unsigned PsrImme = 6;
   localparam int unsigned PsrDmme = 7;

   // Vectors are spaced 64 bytes apart
   localparam int unsigned VectShift = 6;

   typedef enum logic [1:0] {
      StIdle,
      StEnter,
      StRestore,
      StFlush
   } exc_state_e;

   // Data-side causes carry a faulting load/store address
   function automatic logic cause_has_lsa(input logic [3:0] cause);
      return (cause >= CauseDtlbMiss) && (cause <= CauseAlign);
   endfunction

endpackage

// File: rtl/ncpu32k_exc_prio.sv
// ncpu32k_exc_prio
// Combinational priority encoder: picks the lowest-numbered synchronous
// exception, falling back to IRQ only when no exception is pending.
// Ports:
//   exc    in  7  exception request bits, bit n maps to cause n+1
//   irq_ok in  1  IRQ already qualified (enabled, committing, no exc/eret)
//   cause  out 4  selected cause code (0 when none)
//   valid  out 1  a cause was selected
module ncpu32k_exc_prio
   import ncpu32k_exc_pkg::*;
(
   input  logic [6:0] exc,
   input  logic       irq_ok,
   output logic [3:0] cause,
   output logic       valid
);

   always_comb begin
      cause = CauseNone;
      // Scan high to low so the lowest set bit is written last and wins
      for (int i = 6; i >= 0; i--) begin
         if (exc[i]) begin
            cause = 4'(i + 1);
         end
      end
      if ((exc == 7'd0) && irq_ok) begin
         cause = CauseIrq;
      end
      valid = (cause != CauseNone);
   end

endmodule

// File: rtl/ncpu32k_exc_ctrl.sv
// ncpu32k_exc_ctrl
// Exception/interrupt sequencer in front of the PSR/MSR register block.
// Detects exceptions, IRQs and ERET at commit, drives the one-cycle MSR
// writes, then requests a pipeline flush and stalls commit until it is acked.
// Ports:
//   clk, rst_n                clock, asynchronous active-low reset
//   commit_*                  committing instruction: valid, pc, lsa, exc, eret
//   irq                       level interrupt request
//   msr_psr/epsr/epc          current MSR values
//   msr_exp_ent               exception entry strobe
//   msr_{epsr,epc,elsa}_*     EPSR/EPC/ELSA write data and strobes
//   msr_psr_*_nxt/_we         PSR field restore on ERET
//   commit_stall              holds commit while sequencing
//   flush_req/flush_pc        pipeline flush request and redirect target
//   flush_ack                 flush complete
//   exc_cause                 last taken cause
module ncpu32k_exc_ctrl
   import ncpu32k_exc_pkg::*;
#(
   parameter logic [31:0] VECT_BASE = 32'h0000_0000,
   parameter int unsigned PSR_DW    = 10
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              commit_valid,
   input  logic [31:0]       commit_pc,
   input  logic [31:0]       commit_lsa,
   input  logic [6:0]        commit_exc,
   input  logic              commit_eret,
   input  logic              irq,
   input  logic [PSR_DW-1:0] msr_psr,
   input  logic [PSR_DW-1:0] msr_epsr,
   input  logic [31:0]       msr_epc,
   output logic              msr_exp_ent,
   output logic [PSR_DW-1:0] msr_epsr_nxt,
   output logic              msr_epsr_we,
   output logic [31:0]       msr_epc_nxt,
   output logic              msr_epc_we,
   output logic [31:0]       msr_elsa_nxt,
   output logic              msr_elsa_we,
   output logic              msr_psr_cc_nxt,
   output logic              msr_psr_cc_we,
   output logic              msr_psr_rm_nxt,
   output logic              msr_psr_rm_we,
   output logic              msr_psr_ire_nxt,
   output logic              msr_psr_ire_we,
   output logic              msr_psr_imme_nxt,
   output logic              msr_psr_imme_we,
   output logic              msr_psr_dmme_nxt,
   output logic              msr_psr_dmme_we,
   output logic              commit_stall,
   output logic              flush_req,
   output logic [31:0]       flush_pc,
   input  logic              flush_ack,
   output logic [3:0]        exc_cause
);

   exc_state_e        state_q, state_d;
   logic [3:0]        cause_q;
   logic [PSR_DW-1:0] psr_q;
   logic [31:0]       epc_q;
   logic [31:0]       lsa_q;
   logic [31:0]       tgt_q;

   logic              irq_ok;
   logic [3:0]        det_cause;
   logic              det_valid;
   logic              take_exc;
   logic              take_eret;
   logic [31:0]       vec_pc;

   assign irq_ok = irq & msr_psr[PsrIre] & commit_valid & (commit_exc == 7'd0) & ~commit_eret;

   ncpu32k_exc_prio u_prio (
      .exc    (commit_exc),
      .irq_ok (irq_ok),
      .cause  (det_cause),
      .valid  (det_valid)
   );

   assign take_exc  = (state_q == StIdle) & commit_valid & det_valid;
   assign take_eret = (state_q == StIdle) & commit_valid & commit_eret & (commit_exc == 7'd0);
   assign vec_pc    = VECT_BASE + (32'(cause_q) << VectShift);
   assign exc_cause = cause_q;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Snapshot and redirect-target registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cause_q <= CauseNone;
         psr_q   <= '0;
         epc_q   <= '0;
         lsa_q   <= '0;
         tgt_q   <= '0;
      end else begin
         if (take_exc) begin
            cause_q <= det_cause;
            psr_q   <= msr_psr;
            // Syscall returns past itself; everything else re-executes
            epc_q   <= (det_cause == CauseSyscall) ? commit_pc + 32'd4 : commit_pc;
            lsa_q   <= commit_lsa;
         end
         // Hold the redirect target so flush_pc stays stable during FLUSH
         if (state_q == StEnter) begin
            tgt_q <= vec_pc;
         end else if (state_q == StRestore) begin
            tgt_q <= msr_epc;
         end
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (take_exc) begin
               state_d = StEnter;
            end else if (take_eret) begin
               state_d = StRestore;
            end
         end
         StEnter, StRestore: state_d = flush_ack ? StIdle : StFlush;
         StFlush: begin
            if (flush_ack) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Output logic; data outputs are zero unless their strobe is active
   always_comb begin
      msr_exp_ent      = 1'b0;
      msr_epsr_nxt     = '0;
      msr_epsr_we      = 1'b0;
      msr_epc_nxt      = '0;
      msr_epc_we       = 1'b0;
      msr_elsa_nxt     = '0;
      msr_elsa_we      = 1'b0;
      msr_psr_cc_nxt   = 1'b0;
      msr_psr_cc_we    = 1'b0;
      msr_psr_rm_nxt   = 1'b0;
      msr_psr_rm_we    = 1'b0;
      msr_psr_ire_nxt  = 1'b0;
      msr_psr_ire_we   = 1'b0;
      msr_psr_imme_nxt = 1'b0;
      msr_psr_imme_we  = 1'b0;
      msr_psr_dmme_nxt = 1'b0;
      msr_psr_dmme_we  = 1'b0;
      commit_stall     = 1'b0;
      flush_req        = 1'b0;
      flush_pc         = '0;
      unique case (state_q)
         StEnter: begin
            msr_exp_ent  = 1'b1;
            msr_epsr_we  = 1'b1;
            msr_epsr_nxt = psr_q;
            msr_epc_we   = 1'b1;
            msr_epc_nxt  = epc_q;
            if (cause_has_lsa(cause_q)) begin
               msr_elsa_we  = 1'b1;
               msr_elsa_nxt = lsa_q;
            end
            commit_stall = 1'b1;
            flush_req    = 1'b1;
            flush_pc     = vec_pc;
         end
         StRestore: begin
            msr_psr_cc_we    = 1'b1;
            msr_psr_cc_nxt   = msr_epsr[PsrCc];
            msr_psr_rm_we    = 1'b1;
            msr_psr_rm_nxt   = msr_epsr[PsrRm];
            msr_psr_ire_we   = 1'b1;
            msr_psr_ire_nxt  = msr_epsr[PsrIre];
            msr_psr_imme_we  = 1'b1;
            msr_psr_imme_nxt = msr_epsr[PsrImme];
            msr_psr_dmme_we  = 1'b1;
            msr_psr_dmme_nxt = msr_epsr[PsrDmme];
            commit_stall     = 1'b1;
            flush_req        = 1'b1;
            flush_pc         = msr_epc;
         end
         StFlush: begin
            commit_stall = 1'b1;
            flush_req    = 1'b1;
            flush_pc     = tgt_q;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_ncpu32k_exc_ctrl.sv
// tb_ncpu32k_exc_ctrl
// Self-checking bench: directed scenarios plus randomized commits checked
// against a rule-level reference model of cause priority, EPC and vectors.
module tb_ncpu32k_exc_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        commit_valid;
   logic [31:0] commit_pc, commit_lsa;
   logic [6:0]  commit_exc;
   logic        commit_eret, irq;
   logic [9:0]  msr_psr, msr_epsr;
   logic [31:0] msr_epc;
   logic        msr_exp_ent;
   logic [9:0]  msr_epsr_nxt;
   logic        msr_epsr_we;
   logic [31:0] msr_epc_nxt;
   logic        msr_epc_we;
   logic [31:0] msr_elsa_nxt;
   logic        msr_elsa_we;
   logic        cc_nxt, cc_we, rm_nxt, rm_we, ire_nxt, ire_we;
   logic        imme_nxt, imme_we, dmme_nxt, dmme_we;
   logic        commit_stall, flush_req;
   logic [31:0] flush_pc;
   logic        flush_ack;
   logic [3:0]  exc_cause;

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [3:0]  last_cause = 4'd0;

   logic [8:0]  strobes;
   logic [4:0]  rst_we, rst_nxt;
   logic [136:0] all_out;

   assign rst_we  = {cc_we, rm_we, ire_we, imme_we, dmme_we};
   assign rst_nxt = {cc_nxt, rm_nxt, ire_nxt, imme_nxt, dmme_nxt};
   assign strobes = {msr_exp_ent, msr_epsr_we, msr_epc_we, msr_elsa_we, rst_we};
   assign all_out = {strobes, rst_nxt, msr_epsr_nxt, msr_epc_nxt, msr_elsa_nxt,
                     commit_stall, flush_req, flush_pc, exc_cause};

   always #5 clk = ~clk;

   ncpu32k_exc_ctrl #(
      .VECT_BASE (32'h0000_0000),
      .PSR_DW    (10)
   ) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .commit_valid     (commit_valid),
      .commit_pc        (commit_pc),
      .commit_lsa       (commit_lsa),
      .commit_exc       (commit_exc),
      .commit_eret      (commit_eret),
      .irq              (irq),
      .msr_psr          (msr_psr),
      .msr_epsr         (msr_epsr),
      .msr_epc          (msr_epc),
      .msr_exp_ent      (msr_exp_ent),
      .msr_epsr_nxt     (msr_epsr_nxt),
      .msr_epsr_we      (msr_epsr_we),
      .msr_epc_nxt      (msr_epc_nxt),
      .msr_epc_we       (msr_epc_we),
      .msr_elsa_nxt     (msr_elsa_nxt),
      .msr_elsa_we      (msr_elsa_we),
      .msr_psr_cc_nxt   (cc_nxt),
      .msr_psr_cc_we    (cc_we),
      .msr_psr_rm_nxt   (rm_nxt),
      .msr_psr_rm_we    (rm_we),
      .msr_psr_ire_nxt  (ire_nxt),
      .msr_psr_ire_we   (ire_we),
      .msr_psr_imme_nxt (imme_nxt),
      .msr_psr_imme_we  (imme_we),
      .msr_psr_dmme_nxt (dmme_nxt),
      .msr_psr_dmme_we  (dmme_we),
      .commit_stall     (commit_stall),
      .flush_req        (flush_req),
      .flush_pc         (flush_pc),
      .flush_ack        (flush_ack),
      .exc_cause        (exc_cause)
   );

   // Reference model: cause selection straight from the priority rules
   function automatic logic [3:0] m_cause(input logic v, input logic [6:0] exc,
                                          input logic er, input logic iq,
                                          input logic [9:0] psr);
      if (!v) return 4'd0;
      for (int i = 0; i < 7; i++) begin
         if (exc[i]) return 4'(i + 1);
      end
      if (iq && psr[5] && !er) return 4'd8;
      return 4'd0;
   endfunction

   function automatic logic [31:0] m_vec(input logic [3:0] c);
      return 32'h0000_0000 + 32'(c) * 32'd64;
   endfunction

   // Present one commit cycle at a negedge; return at the following negedge
   task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] lsa,
                        input logic [6:0] exc, input logic er, input logic iq,
                        input logic [9:0] psr);
      commit_valid = v;
      commit_pc    = pc;
      commit_lsa   = lsa;
      commit_exc   = exc;
      commit_eret  = er;
      irq          = iq;
      msr_psr      = psr;
      @(posedge clk);
      @(negedge clk);
      commit_valid = 1'b0;
      commit_exc   = 7'd0;
      commit_eret  = 1'b0;
      irq          = 1'b0;
   endtask

   task automatic ack_after(input int lat);
      repeat (lat) @(negedge clk);
      flush_ack = 1'b1;
      @(negedge clk);
      flush_ack = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      n_tests++;
      if (all_out !== '0) begin
         n_fail++; $display("FAIL reset_outputs: got %h want 0", all_out);
      end
      rst_n = 1'b1;
      @(negedge clk);
      n_tests++;
      if (all_out !== '0) begin
         n_fail++; $display("FAIL reset_idle: got %h want 0", all_out);
      end
      last_cause = 4'd0;
   endtask

   task automatic test_illegal();
      drive(1'b1, 32'h100, 32'h0, 7'b000_0100, 1'b0, 1'b0, 10'h0F1);
      n_tests++;
      if ({msr_exp_ent, msr_epsr_we, msr_epc_we, msr_elsa_we} !== 4'b1110) begin
         n_fail++; $display("FAIL ill_strobes: got %b want 1110",
                            {msr_exp_ent, msr_epsr_we, msr_epc_we, msr_elsa_we});
      end
      n_tests++;
      if (msr_epc_nxt !== 32'h100) begin
         n_fail++; $display("FAIL ill_epc: got %h want 100", msr_epc_nxt);
      end
      n_tests++;
      if (msr_epsr_nxt !== 10'h0F1) begin
         n_fail++; $display("FAIL ill_epsr: got %h want 0f1", msr_epsr_nxt);
      end
      n_tests++;
      if (flush_pc !== 32'hC0 || flush_req !== 1'b1 || exc_cause !== 4'd3) begin
         n_fail++; $display("FAIL ill_flush: got pc %h req %b cause %0d want c0 1 3",
                            flush_pc, flush_req, exc_cause);
      end
      @(negedge clk);
      n_tests++;
      if (strobes !== 9'd0 || commit_stall !== 1'b1 || flush_req !== 1'b1 ||
          flush_pc !== 32'hC0) begin
         n_fail++; $display("FAIL ill_hold: got str %h stall %b req %b pc %h",
                            strobes, commit_stall, flush_req, flush_pc);
      end
      ack_after(0);
      n_tests++;
      if (commit_stall !== 1'b0 || flush_req !== 1'b0 || exc_cause !== 4'd3) begin
         n_fail++; $display("FAIL ill_done: got stall %b req %b cause %0d want 0 0 3",
                            commit_stall, flush_req, exc_cause);
      end
   endtask

   task automatic test_syscall_wrap();
      drive(1'b1, 32'hFFFF_FFFC, 32'h0, 7'b000_1000, 1'b0, 1'b0, 10'h0F1);
      n_tests++;
      if (msr_epc_nxt !== 32'h0 || flush_pc !== 32'h100) begin
         n_fail++; $display("FAIL sys_wrap: got epc %h pc %h want 0 100",
                            msr_epc_nxt, flush_pc);
      end
      ack_after(0);
      n_tests++;
      if (commit_stall !== 1'b0) begin
         n_fail++; $display("FAIL sys_early_ack: got stall %b want 0", commit_stall);
      end
   endtask

   task automatic test_priority();
      drive(1'b1, 32'h500, 32'h1234, 7'b100_0001, 1'b0, 1'b1, 10'h020);
      n_tests++;
      if (exc_cause !== 4'd1 || msr_elsa_we !== 1'b0 || flush_pc !== 32'h40) begin
         n_fail++; $display("FAIL prio: got cause %0d elsa_we %b pc %h want 1 0 40",
                            exc_cause, msr_elsa_we, flush_pc);
      end
      ack_after(2);
   endtask

   task automatic test_dpf();
      drive(1'b1, 32'h600, 32'h8000_1234, 7'b010_0000, 1'b0, 1'b0, 10'h000);
      n_tests++;
      if (msr_elsa_nxt !== 32'h8000_1234 || msr_elsa_we !== 1'b1) begin
         n_fail++; $display("FAIL dpf_elsa: got %h we %b want 80001234 1",
                            msr_elsa_nxt, msr_elsa_we);
      end
      n_tests++;
      if (exc_cause !== 4'd6 || flush_pc !== 32'h180) begin
         n_fail++; $display("FAIL dpf_vec: got cause %0d pc %h want 6 180", exc_cause, flush_pc);
      end
      ack_after(1);
   endtask

   task automatic test_irq_gate();
      drive(1'b1, 32'h300, 32'h0, 7'd0, 1'b0, 1'b1, 10'h0D1);
      n_tests++;
      if (msr_exp_ent !== 1'b0 || commit_stall !== 1'b0) begin
         n_fail++; $display("FAIL irq_masked: got ent %b stall %b want 0 0",
                            msr_exp_ent, commit_stall);
      end
      drive(1'b1, 32'h300, 32'h0, 7'd0, 1'b0, 1'b1, 10'h0F1);
      n_tests++;
      if (msr_exp_ent !== 1'b1 || exc_cause !== 4'd8 || msr_epc_nxt !== 32'h300 ||
          flush_pc !== 32'h200) begin
         n_fail++; $display("FAIL irq_take: got ent %b cause %0d epc %h pc %h want 1 8 300 200",
                            msr_exp_ent, exc_cause, msr_epc_nxt, flush_pc);
      end
      ack_after(0);
      last_cause = 4'd8;
   endtask

   task automatic test_eret_reset();
      msr_epsr = 10'h031;
      msr_epc  = 32'h2000;
      drive(1'b1, 32'h400, 32'h0, 7'd0, 1'b1, 1'b0, 10'h0F1);
      n_tests++;
      if (rst_nxt !== 5'b11100 || rst_we !== 5'b11111) begin
         n_fail++; $display("FAIL eret_psr: got nxt %b we %b want 11100 11111", rst_nxt, rst_we);
      end
      n_tests++;
      if (flush_pc !== 32'h2000 || msr_exp_ent !== 1'b0 || msr_epsr_we !== 1'b0 ||
          exc_cause !== last_cause) begin
         n_fail++; $display("FAIL eret_misc: got pc %h ent %b epsr_we %b cause %0d",
                            flush_pc, msr_exp_ent, msr_epsr_we, exc_cause);
      end
      @(negedge clk);
      n_tests++;
      if (rst_we !== 5'd0 || flush_req !== 1'b1 || flush_pc !== 32'h2000) begin
         n_fail++; $display("FAIL eret_flush: got we %b req %b pc %h", rst_we, flush_req, flush_pc);
      end
      rst_n = 1'b0;
      #1;
      n_tests++;
      if (commit_stall !== 1'b0 || flush_req !== 1'b0 || exc_cause !== 4'd0 || strobes !== 9'd0) begin
         n_fail++; $display("FAIL mid_reset: got stall %b req %b cause %0d str %h",
                            commit_stall, flush_req, exc_cause, strobes);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      last_cause = 4'd0;
   endtask

   task automatic test_random();
      logic        v, er, iq, exp_rst;
      logic [31:0] pc, lsa, exp_pc;
      logic [6:0]  exc;
      logic [9:0]  psr;
      logic [3:0]  c;
      int          lat;
      for (int n = 0; n < 80; n++) begin
         v   = ($urandom_range(0, 7) != 0);
         pc  = $urandom;
         lsa = $urandom;
         exc = ($urandom_range(0, 2) == 0) ? 7'($urandom) : 7'd0;
         er  = ($urandom_range(0, 2) == 0);
         iq  = 1'($urandom);
         psr = 10'($urandom) & 10'h0F1;
         msr_epsr = 10'($urandom) & 10'h0F1;
         msr_epc  = $urandom;
         c       = m_cause(v, exc, er, iq, psr);
         exp_rst = (c == 4'd0) && v && er && (exc == 7'd0);
         drive(v, pc, lsa, exc, er, iq, psr);
         if (c != 4'd0) begin
            last_cause = c;
            exp_pc     = m_vec(c);
            n_tests++;
            if (msr_exp_ent !== 1'b1 || exc_cause !== c || flush_pc !== exp_pc) begin
               n_fail++; $display("FAIL rnd_entry: got ent %b cause %0d pc %h want 1 %0d %h",
                                  msr_exp_ent, exc_cause, flush_pc, c, exp_pc);
            end
            n_tests++;
            if (msr_epc_nxt !== ((c == 4'd4) ? pc + 32'd4 : pc) || msr_epsr_nxt !== psr) begin
               n_fail++; $display("FAIL rnd_snap: got epc %h epsr %h (pc %h psr %h cause %0d)",
                                  msr_epc_nxt, msr_epsr_nxt, pc, psr, c);
            end
            n_tests++;
            if (msr_elsa_we !== (c >= 4'd5 && c <= 4'd7) ||
                (msr_elsa_we === 1'b1 && msr_elsa_nxt !== lsa)) begin
               n_fail++; $display("FAIL rnd_elsa: got we %b lsa %h want lsa %h cause %0d",
                                  msr_elsa_we, msr_elsa_nxt, lsa, c);
            end
         end else if (exp_rst) begin
            exp_pc = msr_epc;
            n_tests++;
            if (rst_we !== 5'h1F || rst_nxt !== {msr_epsr[0], msr_epsr[4], msr_epsr[5],
                                                 msr_epsr[6], msr_epsr[7]} ||
                flush_pc !== exp_pc || exc_cause !== last_cause) begin
               n_fail++; $display("FAIL rnd_eret: got we %b nxt %b pc %h cause %0d epsr %h",
                                  rst_we, rst_nxt, flush_pc, exc_cause, msr_epsr);
            end
         end else begin
            n_tests++;
            if (commit_stall !== 1'b0 || strobes !== 9'd0 || flush_req !== 1'b0 ||
                exc_cause !== last_cause) begin
               n_fail++; $display("FAIL rnd_idle: got stall %b str %h req %b cause %0d want cause %0d",
                                  commit_stall, strobes, flush_req, exc_cause, last_cause);
            end
            continue;
         end
         lat = $urandom_range(0, 3);
         for (int k = 0; k < lat; k++) begin
            @(negedge clk);
            msr_epc = $urandom;
            n_tests++;
            if (flush_req !== 1'b1 || commit_stall !== 1'b1 || flush_pc !== exp_pc ||
                strobes !== 9'd0) begin
               n_fail++; $display("FAIL rnd_flush: got req %b stall %b pc %h str %h want pc %h",
                                  flush_req, commit_stall, flush_pc, strobes, exp_pc);
            end
         end
         flush_ack = 1'b1;
         @(negedge clk);
         flush_ack = 1'b0;
         n_tests++;
         if (commit_stall !== 1'b0 || flush_req !== 1'b0) begin
            n_fail++; $display("FAIL rnd_done: got stall %b req %b want 0 0",
                               commit_stall, flush_req);
         end
      end
   endtask

   initial begin
      rst_n        = 1'b0;
      commit_valid = 1'b0;
      commit_pc    = '0;
      commit_lsa   = '0;
      commit_exc   = '0;
      commit_eret  = 1'b0;
      irq          = 1'b0;
      msr_psr      = '0;
      msr_epsr     = '0;
      msr_epc      = '0;
      flush_ack    = 1'b0;
      @(negedge clk);
      test_reset();
      test_illegal();
      test_syscall_wrap();
      test_priority();
      test_dpf();
      test_irq_gate();
      test_eret_reset();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/ncpu32k_exc_ctrl.md
Name: ncpu32k_exc_ctrl

Overview:
- Exception/interrupt sequencer sitting directly upstream of the PSR/MSR register block.
- Takes precise exception and IRQ requests at the commit point and drives that block's exception-entry load (exp_ent), EPSR/EPC/ELSA writes and ERET PSR restore.
- Issues pipeline flush/redirect and holds commit stalled until the flush completes.

Parameters:
- VECT_BASE, 32'h0000_0000, exception vector base; vector = VECT_BASE + (cause << 6).
- PSR_DW, 10, PSR width: bit0 CC, bit4 RM, bit5 IRE, bit6 IMME, bit7 DMME, all others zero.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- commit_valid  in  1  instruction at commit this cycle.
- commit_pc  in  32  PC of committing instruction.
- commit_lsa  in  32  load/store address of committing instruction.
- commit_exc  in  7  one-hot-or-more: [0]itlb_miss [1]ipf [2]illegal [3]syscall [4]dtlb_miss [5]dpf [6]align.
- commit_eret  in  1  committing instruction is ERET.
- irq  in  1  level IRQ from IRQ controller.
- msr_psr  in  PSR_DW  current PSR (non-exception-loaded view).
- msr_epsr  in  PSR_DW  current EPSR.
- msr_epc  in  32  current EPC.
- msr_exp_ent  out  1  exception entry strobe to PSR block.
- msr_epsr_nxt / msr_epsr_we  out  PSR_DW / 1  EPSR write.
- msr_epc_nxt / msr_epc_we  out  32 / 1  EPC write.
- msr_elsa_nxt / msr_elsa_we  out  32 / 1  ELSA write.
- msr_psr_{cc,rm,ire,imme,dmme}_nxt / _we  out  1 / 1 each  ERET restore writes.
- commit_stall  out  1  blocks commit while sequencing.
- flush_req  out  1  pipeline flush request.
- flush_pc  out  32  redirect target.
- flush_ack  in  1  flush complete.
- exc_cause  out  4  last taken cause (debug).

Behaviour:
- Reset: state IDLE; all outputs 0; exc_cause 0; snapshot registers 0. Reset mid-sequence aborts to IDLE with no MSR write.
- Cause codes: itlb_miss=1, ipf=2, illegal=3, syscall=4, dtlb_miss=5, dpf=6, align=7, irq=8. Lower code wins when several are set.
- IRQ is eligible only when irq && msr_psr[5] && commit_valid && commit_exc==0 && !commit_eret. A synchronous exception always beats IRQ and ERET.
- Detection happens in IDLE when commit_valid is high. In the same cycle, latch cause, msr_psr, EPC value and commit_lsa.
  - EPC = commit_pc+4 for syscall; commit_pc otherwise. 32-bit add, wraps modulo 2^32.
- ENTER (exactly 1 cycle, the cycle after detection):
  - msr_exp_ent=1; epsr_we=1 with the latched PSR; epc_we=1.
  - elsa_we=1 only for causes 5..7.
  - flush_req=1; flush_pc=vector. Then go to FLUSH.
- ERET: commit_valid && commit_eret && commit_exc==0 in IDLE → RESTORE (1 cycle).
  - All five psr_*_we=1; each _nxt = matching msr_epsr bit.
  - flush_req=1; flush_pc=msr_epc. Then go to FLUSH.
- FLUSH: flush_req held at 1 and flush_pc stable until flush_ack is sampled high. Then go to IDLE; that cycle is the last with stall.
  - flush_ack arriving already in the ENTER/RESTORE cycle completes immediately; the next state is IDLE.
- commit_stall=1 in every state except IDLE. Requests arriving in non-IDLE states are ignored (IRQ is level, so it re-evaluates in IDLE; the PSR block has cleared IRE by then).
- All MSR write strobes are single-cycle pulses; they are never asserted in IDLE or FLUSH.
- exc_cause updates at detection and holds until the next detection.

Decomposition:
- Package ncpu32k_exc_pkg: cause code constants, PSR bit index constants, state encoding (IDLE, ENTER, RESTORE, FLUSH), VECT shift of 6.
- Sub-module ncpu32k_exc_prio: combinational priority encoder from commit_exc plus the gated IRQ to a 4-bit cause and a valid bit.

Test Plan:
- Reset, then commit illegal at pc 0x100 with msr_psr=0x0F1 → next cycle exp_ent=1, epc_nxt=0x100, epsr_nxt=0x0F1, elsa_we=0, flush_pc=0xC0; stall until flush_ack.
- Syscall at pc 0xFFFF_FFFC → epc_nxt=0x0000_0000 (wrap), flush_pc=0x100.
- Simultaneous itlb_miss+align+irq (IRE=1) → cause 1 only, elsa_we=0, flush_pc=0x40.
- dpf with lsa 0x8000_1234 → elsa_nxt=0x8000_1234, elsa_we=1, cause 6, flush_pc=0x180.
- irq=1 with IRE=0 → no entry. Then IRE=1 → entry with cause 8, epc=commit_pc, flush_pc=0x200.
- ERET with epsr=0x031, epc=0x2000 → rm/ire/cc _nxt=1, imme/dmme _nxt=0, all _we=1 for 1 cycle, flush_pc=0x2000. Assert rst_n low during FLUSH → IDLE, stall=0.
